// File: rtl/avr_io_fabric_if.sv
`default_nettype none
// ============================================================================
//  Module      : avr_io_fabric_if
//  Description : AVR core I/O bus plus interrupt handshake, core <-> fabric.
//  Revision    : 1.0  initial release
// ============================================================================
interface avr_io_fabric_if #(
    parameter int INTR_WIDTH = 2
) ();
    logic [5:0]            io_a;
    logic                  io_re;
    logic                  io_we;
    logic [7:0]            io_do;
    logic [7:0]            io_di;
    logic                  iflag;
    logic [INTR_WIDTH-1:0] ivect;
    logic                  ieack;

    modport master (
        output io_a, io_re, io_we, io_do, ieack,
        input  io_di, iflag, ivect
    );

    modport slave (
        input  io_a, io_re, io_we, io_do, ieack,
        output io_di, iflag, ivect
    );
endinterface
`default_nettype wire

// File: rtl/avr_io_fabric.sv
`default_nettype none
// ============================================================================
//  Module      : avr_io_fabric
//  Description : I/O slot decoder with registered read path and a vectored
//                interrupt controller driving the core's iflag/ivect.
//  Revision    : 1.0  initial release
// ============================================================================
module avr_io_fabric #(
    parameter int         NSLOTS       = 4,
    parameter int         IRQ_SLOT     = 3,
    parameter int         NIRQ         = 4,
    parameter int         INTR_WIDTH   = 2,
    parameter logic [7:0] DEFAULT_DATA = 8'h00
) (
    input  logic                  clk,
    input  logic                  reset,
    avr_io_fabric_if.slave        bus,
    output logic [NSLOTS-1:0]     slot_re,
    output logic [NSLOTS-1:0]     slot_we,
    input  logic [NSLOTS*8-1:0]   slot_dout,
    input  logic [NIRQ-1:0]       irq_in
);
    localparam logic [2:0] c_nslots     = 3'(NSLOTS);
    localparam logic [1:0] c_irq_slot   = 2'(IRQ_SLOT);
    localparam bit         c_irq_mapped = (IRQ_SLOT < NSLOTS);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ASSERT = 2'd1,
        S_GAP    = 2'd2
    } state_t;

    // ---------------- decode ----------------
    logic [1:0] w_slot;
    logic [3:0] w_off;
    logic       w_slot_mapped;
    logic       w_irq_sel;
    logic       w_fwd;

    assign w_slot        = bus.io_a[5:4];
    assign w_off         = bus.io_a[3:0];
    assign w_slot_mapped = ({1'b0, w_slot} < c_nslots);
    assign w_irq_sel     = c_irq_mapped && (w_slot == c_irq_slot);
    assign w_fwd         = w_slot_mapped && !w_irq_sel;

    for (genvar s = 0; s < NSLOTS; s++) begin : g_strobe
        assign slot_re[s] = bus.io_re && w_fwd && (w_slot == 2'(s));
        assign slot_we[s] = bus.io_we && w_fwd && (w_slot == 2'(s));
    end

    // ---------------- interrupt registers ----------------
    logic [NIRQ-1:0] r_ien, r_pend, r_iedge, r_irq_q;
    logic [NIRQ-1:0] w_pend_eff, w_req, w_set, w_w1c, w_clr_ack, w_wdata;
    logic            w_irq_we;
    logic [7:0]      w_irq_rdata;

    state_t                r_state, w_state_nx;
    logic                  r_iflag, w_iflag_nx;
    logic [INTR_WIDTH-1:0] r_ivect, w_ivect_nx, w_win;
    logic                  w_req_cur;

    // Level-mode bits expose the live request; edge-mode bits use the sticky latch.
    assign w_pend_eff = (r_pend & r_iedge) | (irq_in & ~r_iedge);
    assign w_req      = w_pend_eff & r_ien;
    assign w_irq_we   = bus.io_we && w_irq_sel;
    assign w_wdata    = bus.io_do[NIRQ-1:0];
    assign w_set      = irq_in & ~r_irq_q & r_iedge;
    assign w_w1c      = (w_irq_we && w_off == 4'd1) ? (w_wdata & r_iedge) : '0;

    for (genvar i = 0; i < NIRQ; i++) begin : g_ack_clr
        assign w_clr_ack[i] = (r_state == S_ASSERT) && bus.ieack &&
                              (r_ivect == INTR_WIDTH'(i));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ien   <= '0;
            r_pend  <= '0;
            r_iedge <= '1;
            r_irq_q <= '0;
        end else begin
            r_irq_q <= irq_in;
            // Set is ORed in last so a new edge beats W1C and ack clears.
            r_pend  <= ((r_pend & ~w_w1c & ~w_clr_ack) | w_set) & r_iedge;
            if (w_irq_we && w_off == 4'd0) r_ien   <= w_wdata;
            if (w_irq_we && w_off == 4'd2) r_iedge <= w_wdata;
        end
    end

    always_comb begin
        w_irq_rdata = DEFAULT_DATA;
        case (w_off)
            4'd0: begin w_irq_rdata = '0; w_irq_rdata[NIRQ-1:0] = r_ien;      end
            4'd1: begin w_irq_rdata = '0; w_irq_rdata[NIRQ-1:0] = w_pend_eff; end
            4'd2: begin w_irq_rdata = '0; w_irq_rdata[NIRQ-1:0] = r_iedge;    end
            default: ;
        endcase
    end

    // ---------------- read path ----------------
    logic [2:0] r_rd_slot;
    logic       r_rd_pend;
    logic [7:0] r_irq_rdata, r_di_hold, w_sel_dout, w_di;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_slot   <= c_nslots;
            r_rd_pend   <= 1'b0;
            r_irq_rdata <= DEFAULT_DATA;
            r_di_hold   <= DEFAULT_DATA;
        end else begin
            r_rd_pend <= bus.io_re;
            if (bus.io_re) begin
                r_rd_slot   <= {1'b0, w_slot};
                r_irq_rdata <= w_irq_rdata;
            end
            if (r_rd_pend) r_di_hold <= w_di;
        end
    end

    always_comb begin
        w_sel_dout = DEFAULT_DATA;
        for (int s = 0; s < NSLOTS; s++) begin
            if (r_rd_slot == 3'(s)) w_sel_dout = slot_dout[8*s +: 8];
        end
        if (!r_rd_pend)
            w_di = r_di_hold;
        else if (r_rd_slot >= c_nslots)
            w_di = DEFAULT_DATA;
        else if (c_irq_mapped && r_rd_slot == {1'b0, c_irq_slot})
            w_di = r_irq_rdata;
        else
            w_di = w_sel_dout;
    end

    assign bus.io_di = w_di;

    // ---------------- arbitration and handshake FSM ----------------
    always_comb begin
        w_win     = '0;
        w_req_cur = 1'b0;
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (w_req[i]) w_win = INTR_WIDTH'(i);
        end
        for (int i = 0; i < NIRQ; i++) begin
            if (r_ivect == INTR_WIDTH'(i)) w_req_cur = w_req[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_iflag <= 1'b0;
            r_ivect <= '0;
        end else begin
            r_state <= w_state_nx;
            r_iflag <= w_iflag_nx;
            r_ivect <= w_ivect_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_iflag_nx = r_iflag;
        w_ivect_nx = r_ivect;
        case (r_state)
            S_IDLE: begin
                if (|w_req) begin
                    w_ivect_nx = w_win;
                    w_iflag_nx = 1'b1;
                    w_state_nx = S_ASSERT;
                end
            end
            S_ASSERT: begin
                if (bus.ieack) begin
                    w_iflag_nx = 1'b0;
                    w_state_nx = S_GAP;
                end else if (!w_req_cur) begin
                    w_iflag_nx = 1'b0;
                    w_state_nx = S_IDLE;
                end
            end
            S_GAP:   w_state_nx = S_IDLE;
            default: begin
                w_iflag_nx = 1'b0;
                w_state_nx = S_IDLE;
            end
        endcase
    end

    assign bus.iflag = r_iflag;
    assign bus.ivect = r_ivect;

endmodule
`default_nettype wire

// File: tb/tb_avr_io_fabric.sv
`default_nettype none
// ============================================================================
//  Module      : tb_avr_io_fabric
//  Description : Vector table for decode/read path plus directed IRQ sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_avr_io_fabric;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  slot_re, slot_we;
    logic [31:0] slot_dout;
    logic [3:0]  irq_in;

    int n_tests = 0;
    int n_fail  = 0;

    avr_io_fabric_if #(.INTR_WIDTH(2)) bus ();

    avr_io_fabric #(
        .NSLOTS(4), .IRQ_SLOT(3), .NIRQ(4), .INTR_WIDTH(2), .DEFAULT_DATA(8'h00)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .slot_re   (slot_re),
        .slot_we   (slot_we),
        .slot_dout (slot_dout),
        .irq_in    (irq_in)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  a;
        logic        re;
        logic        we;
        logic [7:0]  d;
        logic [31:0] sdout;
        logic [3:0]  exp_re;
        logic [3:0]  exp_we;
        logic [7:0]  exp_di;
    } vec_t;

    vec_t       vecs[8];
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic io_write(input logic [5:0] a, input logic [7:0] d);
        bus.io_a  = a;
        bus.io_do = d;
        bus.io_we = 1'b1;
        cyc();
        bus.io_we = 1'b0;
    endtask

    task automatic io_read(input logic [5:0] a, output logic [7:0] d);
        bus.io_a  = a;
        bus.io_re = 1'b1;
        cyc();
        bus.io_re = 1'b0;
        d = bus.io_di;
    endtask

    task automatic wait_iflag(input string name);
        int k;
        k = 0;
        while (bus.iflag !== 1'b1 && k < 8) begin
            cyc();
            k++;
        end
        check(name, 32'(bus.iflag), 32'd1);
    endtask

    task automatic ack();
        bus.ieack = 1'b1;
        cyc();
        bus.ieack = 1'b0;
    endtask

    initial begin
        logic [7:0] rd;
        logic [7:0] exp_di;

        vecs[0] = '{6'h12, 1'b0, 1'b1, 8'hA5, 32'h0000_0000, 4'b0000, 4'b0010, 8'h00};
        vecs[1] = '{6'h05, 1'b1, 1'b0, 8'h00, 32'h0000_003C, 4'b0001, 4'b0000, 8'h3C};
        vecs[2] = '{6'h31, 1'b0, 1'b1, 8'h00, 32'h0000_0000, 4'b0000, 4'b0000, 8'h00};
        vecs[3] = '{6'h25, 1'b1, 1'b0, 8'h00, 32'h0077_0000, 4'b0100, 4'b0000, 8'h77};
        vecs[4] = '{6'h1F, 1'b1, 1'b1, 8'h11, 32'h0000_5A00, 4'b0010, 4'b0010, 8'h5A};
        vecs[5] = '{6'h32, 1'b1, 1'b0, 8'h00, 32'hFFFF_FFFF, 4'b0000, 4'b0000, 8'h0F};
        vecs[6] = '{6'h3F, 1'b1, 1'b0, 8'h00, 32'hFFFF_FFFF, 4'b0000, 4'b0000, 8'h00};
        vecs[7] = '{6'h30, 1'b1, 1'b0, 8'h00, 32'hFFFF_FFFF, 4'b0000, 4'b0000, 8'h00};

        reset     = 1'b1;
        bus.io_a  = '0;
        bus.io_re = 1'b0;
        bus.io_we = 1'b0;
        bus.io_do = '0;
        bus.ieack = 1'b0;
        slot_dout = '0;
        irq_in    = '0;
        repeat (3) cyc();
        reset = 1'b0;
        cyc();
        check("rst_io_di", 32'(bus.io_di), 32'h00);
        check("rst_iflag", 32'(bus.iflag), 32'd0);
        check("rst_ivect", 32'(bus.ivect), 32'd0);

        // Decode and read path vectors; expected read data goes through the scoreboard.
        for (int i = 0; i < 8; i++) begin
            bus.io_a  = vecs[i].a;
            bus.io_re = vecs[i].re;
            bus.io_we = vecs[i].we;
            bus.io_do = vecs[i].d;
            slot_dout = vecs[i].sdout;
            #1;
            check($sformatf("v%0d_slot_re", i), 32'(slot_re), 32'(vecs[i].exp_re));
            check($sformatf("v%0d_slot_we", i), 32'(slot_we), 32'(vecs[i].exp_we));
            if (vecs[i].re) exp_q.push_back(vecs[i].exp_di);
            cyc();
            bus.io_re = 1'b0;
            bus.io_we = 1'b0;
            if (exp_q.size() > 0) begin
                exp_di = exp_q.pop_front();
                check($sformatf("v%0d_io_di", i), 32'(bus.io_di), 32'(exp_di));
                cyc();
                slot_dout = ~vecs[i].sdout;
                #1;
                check($sformatf("v%0d_hold", i), 32'(bus.io_di), 32'(exp_di));
            end
        end
        slot_dout = '0;

        // Edge interrupt and acknowledge
        io_write(6'h30, 8'h0F);
        irq_in = 4'b0100;
        cyc();
        irq_in = 4'b0000;
        wait_iflag("edge_iflag");
        check("edge_ivect", 32'(bus.ivect), 32'd2);
        io_read(6'h31, rd);
        check("edge_pend_set", 32'(rd), 32'h04);
        ack();
        check("edge_ack_iflag", 32'(bus.iflag), 32'd0);
        io_read(6'h31, rd);
        check("edge_pend_clr", 32'(rd), 32'h00);
        repeat (2) cyc();

        // Priority, no preemption, 2-cycle spacing
        irq_in = 4'b1010;
        cyc();
        irq_in = 4'b0000;
        wait_iflag("prio_iflag");
        check("prio_ivect1", 32'(bus.ivect), 32'd1);
        ack();
        check("prio_gap1", 32'(bus.iflag), 32'd0);
        cyc();
        check("prio_gap2", 32'(bus.iflag), 32'd0);
        cyc();
        check("prio_reassert", 32'(bus.iflag), 32'd1);
        check("prio_ivect3", 32'(bus.ivect), 32'd3);
        ack();
        repeat (2) cyc();

        // Retract by disabling, then a stray ack
        irq_in = 4'b0001;
        cyc();
        irq_in = 4'b0000;
        wait_iflag("retr_iflag");
        check("retr_ivect", 32'(bus.ivect), 32'd0);
        io_write(6'h30, 8'h00);
        cyc();
        check("retr_drop", 32'(bus.iflag), 32'd0);
        ack();
        cyc();
        check("retr_stay_low", 32'(bus.iflag), 32'd0);
        io_read(6'h31, rd);
        check("retr_pend_kept", 32'(rd), 32'h01);

        // W1C alone, then W1C colliding with a new edge
        io_write(6'h31, 8'h01);
        io_read(6'h31, rd);
        check("w1c_clear", 32'(rd), 32'h00);
        bus.io_a  = 6'h31;
        bus.io_do = 8'h01;
        bus.io_we = 1'b1;
        irq_in    = 4'b0001;
        cyc();
        bus.io_we = 1'b0;
        irq_in    = 4'b0000;
        io_read(6'h31, rd);
        check("collision_set_wins", 32'(rd), 32'h01);
        io_write(6'h31, 8'h01);

        // Level mode bit 0 reads the live request
        io_write(6'h32, 8'h0E);
        irq_in = 4'b0001;
        io_read(6'h31, rd);
        check("level_live_hi", 32'(rd), 32'h01);
        irq_in = 4'b0000;
        io_read(6'h31, rd);
        check("level_live_lo", 32'(rd), 32'h00);
        io_write(6'h32, 8'h0F);
        cyc();

        // Reset in the middle of a handshake
        io_write(6'h30, 8'h0F);
        irq_in = 4'b0100;
        cyc();
        irq_in = 4'b0000;
        wait_iflag("rst_pre_iflag");
        reset     = 1'b1;
        bus.io_a  = 6'h12;
        bus.io_we = 1'b1;
        #1;
        check("rst_strobe", 32'(slot_we), 32'b0010);
        cyc();
        bus.io_we = 1'b0;
        check("rst_mid_iflag", 32'(bus.iflag), 32'd0);
        check("rst_mid_ivect", 32'(bus.ivect), 32'd0);
        check("rst_mid_io_di", 32'(bus.io_di), 32'h00);
        reset = 1'b0;
        io_read(6'h30, rd);
        check("rst_ien", 32'(rd), 32'h00);
        io_read(6'h32, rd);
        check("rst_iedge", 32'(rd), 32'h0F);
        repeat (3) cyc();
        check("rst_no_irq", 32'(bus.iflag), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected $finish");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
